matrix_multiplier_param: RTL and testbench
==========================================

MATRIX_MULTIPLIER_PARAM -- requirements
Module: matrix_multiplier_param

Interface
REQ-001 Parameter N, default 2: matrix dimension (N x N); legal range 2..8.
REQ-002 Parameter W, default 8: element width of A and B.
REQ-003 Parameter SIGNED, default 0: 0 = unsigned operands, 1 = two's-complement operands.
REQ-004 Derived OW = 2*W + clog2(N): result element width.
REQ-005 clk  in  1  single clock; all state on rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 start  in  1  begin a new operation; sampled only in IDLE.
REQ-008 in_valid  in  1  in_a/in_b pair valid.
REQ-009 in_ready  out  1  block accepts a pair this cycle.
REQ-010 in_a  in  W  element of A, row-major order.
REQ-011 in_b  in  W  element of B, row-major order.
REQ-012 out_valid  out  1  out_data holds a valid element of C.
REQ-013 out_ready  in  1  consumer accepts out_data this cycle.
REQ-014 out_data  out  OW  element of C = A*B, row-major order.
REQ-015 out_last  out  1  high with the final element C[N-1][N-1].
REQ-016 busy  out  1  high in any state other than IDLE.

Function
REQ-017 FSM states IDLE, LOAD, COMPUTE, OUTPUT; one-hot or binary at implementer's choice.
REQ-018 IDLE -> LOAD on clock edge with start=1; start in any other state is ignored.
REQ-019 LOAD: in_ready=1; a pair is accepted on each edge with in_valid & in_ready; pair k (0..N*N-1) is written to A[k/N][k%N] and B[k/N][k%N].
REQ-020 LOAD -> COMPUTE on the edge accepting pair N*N-1; in_ready=0 from the next cycle.
REQ-021 COMPUTE: one multiply-accumulate per cycle, exactly N*N*N cycles; per C element, accumulator cleared then summed over k=0..N-1 of A[i][k]*B[k][j]; result stored in C buffer.
REQ-022 Products and sums computed at full OW precision; SIGNED=1 sign-extends operands, SIGNED=0 zero-extends; no overflow or saturation possible.
REQ-023 COMPUTE -> OUTPUT after the final MAC; out_valid rises the cycle after the last COMPUTE cycle.
REQ-024 OUTPUT: out_data=C[m/N][m%N] for index m; m advances only on out_valid & out_ready.
REQ-025 While out_valid=1 and out_ready=0, out_data, out_last and out_valid hold stable.
REQ-026 out_last=1 only when m=N*N-1 and out_valid=1.
REQ-027 Transfer of m=N*N-1 -> IDLE; out_valid=0 next cycle; new start accepted from that IDLE cycle.
REQ-028 in_valid outside LOAD has no effect; in_a/in_b are ignored.
REQ-029 Gaps in in_valid during LOAD stall LOAD indefinitely; no timeout.
REQ-030 Minimum latency, last input accepted -> first out_valid: N*N*N+1 cycles.

Reset
REQ-031 rst=1 forces IDLE asynchronously, in any state, including mid-LOAD, mid-COMPUTE and mid-OUTPUT.
REQ-032 Reset values: in_ready=0, out_valid=0, out_last=0, busy=0, out_data=0, all counters 0.
REQ-033 A, B and C buffers need no reset; stale contents are never visible at out_data.
REQ-034 A partially loaded or partially output operation is discarded on reset; next start begins from pair 0.

Verification
REQ-035 N=2, W=8, SIGNED=0: A=[1,2,3,4], B=[5,6,7,8], out_ready=1 -> out_data 19,22,43,50; out_last with 50; first out_valid 9 cycles after last pair.
REQ-036 N=2, W=8, SIGNED=0, all elements 255 -> four outputs of 130050 (17 bits, no wrap).
REQ-037 N=2, W=8, SIGNED=1: A=[-128,-128,1,-1], B=[-128,0,-128,2] -> 32768, -256, 0, -2.
REQ-038 N=3, A=identity, random B, out_ready toggled pseudo-randomly -> outputs equal B row-major; out_data stable during stalls; exactly 9 transfers.
REQ-039 rst pulsed mid-COMPUTE, then new start with REQ-035 data -> all outputs 0 during reset; correct results 19,22,43,50 afterwards.
REQ-040 start asserted during LOAD and OUTPUT, in_valid asserted in IDLE -> no state change, no extra pair consumed, busy unchanged.

Source files
------------

// File: rtl/matrix_multiplier_param_if.sv
// matrix_multiplier_param_if: load/compute/output handshake bundle for the matrix multiplier
interface matrix_multiplier_param_if #(
  parameter int W  = 8,
  parameter int OW = 17
);
  logic          start;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_a;
  logic [W-1:0]  in_b;
  logic          out_valid;
  logic          out_ready;
  logic [OW-1:0] out_data;
  logic          out_last;
  logic          busy;
  modport master (
    output start, in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_data, out_last, busy
  );
  modport slave (
    input  start, in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_data, out_last, busy
  );
endinterface

// File: rtl/matrix_multiplier_param.sv
// matrix_multiplier_param: N x N matrix product C = A*B, streamed in and out row-major, one MAC per cycle
module matrix_multiplier_param #(
  parameter int N      = 2,
  parameter int W      = 8,
  parameter bit SIGNED = 1'b0
) (
  input logic clk,
  input logic rst,
  matrix_multiplier_param_if.slave bus
);
  localparam int OW = 2*W + $clog2(N);
  localparam int NN = N*N;
  localparam int CW = $clog2(NN);
  localparam int IW = $clog2(N);
  typedef enum logic [1:0] {IDLE, LOAD, COMPUTE, OUTPUT} state_t;
  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [IW-1:0] i_q, j_q, k_q;
  logic [OW-1:0] acc_q, out_data_q;
  logic          in_ready_q, out_valid_q, out_last_q, busy_q;
  logic [W-1:0]  a_q [NN];
  logic [W-1:0]  b_q [NN];
  logic [OW-1:0] c_q [NN];
  logic [CW-1:0] a_idx, b_idx, c_idx, cnt_nx;
  logic [OW-1:0] mac_d;
  logic          load_en, il, jl, kl, cnt_last;

  // Widening to OW first makes the truncated product exact for both signednesses.
  function automatic logic [OW-1:0] ext(input logic [W-1:0] x);
    return SIGNED ? {{(OW-W){x[W-1]}}, x} : {{(OW-W){1'b0}}, x};
  endfunction

  always_comb begin
    a_idx    = CW'(int'(i_q) * N + int'(k_q));
    b_idx    = CW'(int'(k_q) * N + int'(j_q));
    c_idx    = CW'(int'(i_q) * N + int'(j_q));
    cnt_nx   = cnt_q + 1'b1;
    cnt_last = cnt_q == CW'(NN-1);
    il       = i_q == IW'(N-1);
    jl       = j_q == IW'(N-1);
    kl       = k_q == IW'(N-1);
    mac_d    = (k_q == '0 ? '0 : acc_q) + ext(a_q[a_idx]) * ext(b_q[b_idx]);
    load_en  = state_q == LOAD && bus.in_valid;
  end

  always_ff @(posedge clk) begin
    if (load_en) begin
      a_q[cnt_q] <= bus.in_a;
      b_q[cnt_q] <= bus.in_b;
    end
    if (state_q == COMPUTE && kl) c_q[c_idx] <= mac_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      i_q         <= '0;
      j_q         <= '0;
      k_q         <= '0;
      acc_q       <= '0;
      out_data_q  <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (bus.start) begin
          state_q    <= LOAD;
          in_ready_q <= 1'b1;
          busy_q     <= 1'b1;
          cnt_q      <= '0;
        end
        LOAD: if (load_en) begin
          cnt_q <= cnt_last ? '0 : cnt_nx;
          if (cnt_last) begin
            state_q    <= COMPUTE;
            in_ready_q <= 1'b0;
          end
        end
        COMPUTE: begin
          acc_q <= mac_d;
          k_q   <= kl ? '0 : k_q + 1'b1;
          if (kl) j_q <= jl ? '0 : j_q + 1'b1;
          if (kl && jl) i_q <= il ? '0 : i_q + 1'b1;
          if (il && jl && kl) begin
            state_q     <= OUTPUT;
            out_valid_q <= 1'b1;
            out_data_q  <= c_q[0];
            out_last_q  <= 1'b0;
          end
        end
        OUTPUT: if (bus.out_ready) begin
          if (cnt_last) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
            busy_q      <= 1'b0;
          end else begin
            cnt_q      <= cnt_nx;
            out_data_q <= c_q[cnt_nx];
            out_last_q <= cnt_nx == CW'(NN-1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_last  = out_last_q;
  assign bus.busy      = busy_q;
endmodule

// File: tb/tb_matrix_multiplier_param.sv
// tb_matrix_multiplier_param: randomized model-checked bench over three configurations (2x2 unsigned, 2x2 signed, 3x3 unsigned)
module tb_matrix_multiplier_param;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic start, in_valid, out_ready;
  logic [7:0] in_a, in_b;
  int sel;
  logic in_ready, out_valid, out_last, busy;
  logic [17:0] out_data;

  matrix_multiplier_param_if #(.W(8), .OW(17)) if_u2 ();
  matrix_multiplier_param_if #(.W(8), .OW(17)) if_s2 ();
  matrix_multiplier_param_if #(.W(8), .OW(18)) if_u3 ();

  matrix_multiplier_param #(.N(2), .W(8), .SIGNED(1'b0)) dut_u2 (.clk(clk), .rst(rst), .bus(if_u2.slave));
  matrix_multiplier_param #(.N(2), .W(8), .SIGNED(1'b1)) dut_s2 (.clk(clk), .rst(rst), .bus(if_s2.slave));
  matrix_multiplier_param #(.N(3), .W(8), .SIGNED(1'b0)) dut_u3 (.clk(clk), .rst(rst), .bus(if_u3.slave));

  assign if_u2.start = start && sel == 0;
  assign if_s2.start = start && sel == 1;
  assign if_u3.start = start && sel == 2;
  assign if_u2.in_valid = in_valid && sel == 0;
  assign if_s2.in_valid = in_valid && sel == 1;
  assign if_u3.in_valid = in_valid && sel == 2;
  assign if_u2.in_a = in_a;
  assign if_s2.in_a = in_a;
  assign if_u3.in_a = in_a;
  assign if_u2.in_b = in_b;
  assign if_s2.in_b = in_b;
  assign if_u3.in_b = in_b;
  assign if_u2.out_ready = out_ready;
  assign if_s2.out_ready = out_ready;
  assign if_u3.out_ready = out_ready;
  assign in_ready  = sel == 0 ? if_u2.in_ready  : sel == 1 ? if_s2.in_ready  : if_u3.in_ready;
  assign out_valid = sel == 0 ? if_u2.out_valid : sel == 1 ? if_s2.out_valid : if_u3.out_valid;
  assign out_last  = sel == 0 ? if_u2.out_last  : sel == 1 ? if_s2.out_last  : if_u3.out_last;
  assign busy      = sel == 0 ? if_u2.busy      : sel == 1 ? if_s2.busy      : if_u3.busy;
  assign out_data  = sel == 0 ? {1'b0, if_u2.out_data} :
                     sel == 1 ? {if_s2.out_data[16], if_s2.out_data} : if_u3.out_data;

  int passed = 0, total = 0;
  int ma[64], mb[64];
  logic [17:0] got[$];
  bit lasts[$];
  int unstable;

  function automatic logic [17:0] ref_c(input int n, input int m);
    longint s = 0;
    for (int k = 0; k < n; k++) s += longint'(ma[(m / n) * n + k]) * longint'(mb[k * n + m % n]);
    return 18'(s);
  endfunction

  task automatic rand_mats(input int n, input bit sgn);
    for (int p = 0; p < n * n; p++) begin
      ma[p] = sgn ? int'($urandom_range(0, 255)) - 128 : int'($urandom_range(0, 255));
      mb[p] = sgn ? int'($urandom_range(0, 255)) - 128 : int'($urandom_range(0, 255));
    end
  endtask

  task automatic basic_mats();
    for (int p = 0; p < 4; p++) begin
      ma[p] = p + 1;
      mb[p] = p + 5;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic load(input int p0, input int np, input bit gaps);
    for (int p = p0; p < p0 + np; p++) begin
      if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
      in_valid = 1'b1;
      in_a = 8'(ma[p]);
      in_b = 8'(mb[p]);
      @(negedge clk);
      in_valid = 1'b0;
      in_a = 8'($urandom);
      in_b = 8'($urandom);
    end
  endtask

  task automatic wait_valid(output int edges);
    edges = 0;
    while (!out_valid && edges < 2000) begin
      @(negedge clk);
      edges++;
    end
  endtask

  task automatic collect(input int n, input bit rnd);
    logic [17:0] d;
    bit l, v, r;
    got.delete();
    lasts.delete();
    unstable = 0;
    for (int c = 0; c < 5000 && got.size() < n * n; c++) begin
      r = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      out_ready = r;
      d = out_data;
      l = out_last;
      v = out_valid;
      if (v && r) begin
        got.push_back(d);
        lasts.push_back(l);
      end
      @(negedge clk);
      if (v && !r && (out_data !== d || out_last !== l || out_valid !== 1'b1)) unstable++;
    end
    out_ready = 1'b1;
  endtask

  task automatic test_reset();
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      total++;
      if ({in_ready, out_valid, out_last, busy, out_data} !== 22'd0)
        $display("FAIL reset_values dut%0d: got rdy=%b vld=%b last=%b busy=%b data=%0d required all 0",
                 s, in_ready, out_valid, out_last, busy, out_data);
      else passed++;
    end
  endtask

  task automatic test_basic();
    int lat;
    int exp_c[4] = '{19, 22, 43, 50};
    sel = 0;
    basic_mats();
    pulse_start();
    load(0, 4, 1'b0);
    wait_valid(lat);
    total++;
    if (lat + 1 != 9) $display("FAIL basic_latency: got %0d cycles required 9", lat + 1);
    else passed++;
    collect(2, 1'b0);
    for (int m = 0; m < 4; m++) begin
      total++;
      if (got.size() > m && got[m] === 18'(exp_c[m]) && lasts[m] === (m == 3)) passed++;
      else $display("FAIL basic_out[%0d]: got %0d last=%b required %0d last=%b",
                    m, got.size() > m ? got[m] : 18'h3ffff, got.size() > m ? lasts[m] : 1'b0, exp_c[m], m == 3);
    end
    total++;
    if (busy !== 1'b0 || out_valid !== 1'b0) $display("FAIL basic_idle: got busy=%b vld=%b required 0 0", busy, out_valid);
    else passed++;
  endtask

  task automatic test_max();
    sel = 0;
    for (int p = 0; p < 4; p++) begin
      ma[p] = 255;
      mb[p] = 255;
    end
    pulse_start();
    load(0, 4, 1'b1);
    collect(2, 1'b1);
    for (int m = 0; m < 4; m++) begin
      total++;
      if (got.size() > m && got[m] === 18'd130050) passed++;
      else $display("FAIL max_out[%0d]: got %0d required 130050", m, got.size() > m ? got[m] : 18'h3ffff);
    end
  endtask

  task automatic test_signed();
    int exp_c[4] = '{32768, -256, 0, -2};
    sel = 1;
    ma[0] = -128; ma[1] = -128; ma[2] = 1;    ma[3] = -1;
    mb[0] = -128; mb[1] = 0;    mb[2] = -128; mb[3] = 2;
    pulse_start();
    load(0, 4, 1'b0);
    collect(2, 1'b0);
    for (int m = 0; m < 4; m++) begin
      total++;
      if (got.size() > m && got[m] === 18'(exp_c[m])) passed++;
      else $display("FAIL signed_out[%0d]: got %0d required %0d",
                    m, got.size() > m ? $signed(got[m]) : 18'sh1ffff, exp_c[m]);
    end
  endtask

  task automatic test_identity_stall();
    int extra = 0;
    sel = 2;
    for (int p = 0; p < 9; p++) begin
      ma[p] = (p / 3 == p % 3) ? 1 : 0;
      mb[p] = int'($urandom_range(0, 255));
    end
    pulse_start();
    load(0, 9, 1'b1);
    collect(3, 1'b1);
    for (int c = 0; c < 6; c++) begin
      if (out_valid) extra++;
      @(negedge clk);
    end
    total++;
    if (got.size() != 9 || extra != 0) $display("FAIL identity_count: got %0d transfers (+%0d) required 9", got.size(), extra);
    else passed++;
    total++;
    if (unstable != 0) $display("FAIL identity_stall_stable: got %0d unstable stalls required 0", unstable);
    else passed++;
    for (int m = 0; m < 9; m++) begin
      total++;
      if (got.size() > m && got[m] === 18'(mb[m]) && lasts[m] === (m == 8)) passed++;
      else $display("FAIL identity_out[%0d]: got %0d required %0d", m, got.size() > m ? got[m] : 18'h3ffff, mb[m]);
    end
  endtask

  task automatic test_random();
    int n, bad;
    for (int r = 0; r < 9; r++) begin
      sel = r % 3;
      n = sel == 2 ? 3 : 2;
      rand_mats(n, sel == 1);
      pulse_start();
      load(0, n * n, 1'b1);
      collect(n, 1'b1);
      bad = 0;
      for (int m = 0; m < n * n; m++)
        if (got.size() <= m || got[m] !== ref_c(n, m) || lasts[m] !== (m == n * n - 1)) bad++;
      total++;
      if (bad != 0 || unstable != 0 || got.size() != n * n)
        $display("FAIL random_round%0d dut%0d: got %0d wrong, %0d unstable, %0d transfers required 0 0 %0d",
                 r, sel, bad, unstable, got.size(), n * n);
      else passed++;
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    int exp_c[4] = '{19, 22, 43, 50};
    sel = 0;
    for (int r = 0; r < 3; r++) begin
      rand_mats(2, 1'b0);
      pulse_start();
      load(0, r == 0 ? 2 : 4, 1'b0);
      if (r == 1) repeat (3) @(negedge clk);
      if (r == 2) begin
        wait_valid(lat);
        out_ready = 1'b0;
        @(negedge clk);
      end
      rst = 1'b1;
      #1;
      total++;
      if ({in_ready, out_valid, out_last, busy, out_data} !== 22'd0)
        $display("FAIL reset_mid%0d_async: got rdy=%b vld=%b last=%b busy=%b data=%0d required all 0",
                 r, in_ready, out_valid, out_last, busy, out_data);
      else passed++;
      @(negedge clk);
      total++;
      if ({in_ready, out_valid, out_last, busy, out_data} !== 22'd0)
        $display("FAIL reset_mid%0d_held: got vld=%b busy=%b data=%0d required all 0", r, out_valid, busy, out_data);
      else passed++;
      rst = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      basic_mats();
      pulse_start();
      load(0, 4, 1'b0);
      collect(2, 1'b0);
      for (int m = 0; m < 4; m++) begin
        total++;
        if (got.size() > m && got[m] === 18'(exp_c[m])) passed++;
        else $display("FAIL reset_mid%0d_out[%0d]: got %0d required %0d", r, m, got.size() > m ? got[m] : 18'h3ffff, exp_c[m]);
      end
    end
  endtask

  task automatic test_ignored();
    int lat;
    int exp_c[4] = '{19, 22, 43, 50};
    sel = 0;
    in_valid = 1'b1;
    in_a = 8'd99;
    in_b = 8'd77;
    repeat (3) @(negedge clk);
    in_valid = 1'b0;
    total++;
    if (busy !== 1'b0 || in_ready !== 1'b0) $display("FAIL ignore_idle_valid: got busy=%b rdy=%b required 0 0", busy, in_ready);
    else passed++;
    basic_mats();
    pulse_start();
    load(0, 2, 1'b0);
    start = 1'b1;
    repeat (2) @(negedge clk);
    start = 1'b0;
    total++;
    if (busy !== 1'b1 || in_ready !== 1'b1) $display("FAIL ignore_load_start: got busy=%b rdy=%b required 1 1", busy, in_ready);
    else passed++;
    load(2, 2, 1'b0);
    wait_valid(lat);
    out_ready = 1'b0;
    start = 1'b1;
    repeat (3) @(negedge clk);
    start = 1'b0;
    total++;
    if (out_valid !== 1'b1 || out_data !== 18'd19 || busy !== 1'b1)
      $display("FAIL ignore_output_start: got vld=%b data=%0d busy=%b required 1 19 1", out_valid, out_data, busy);
    else passed++;
    collect(2, 1'b0);
    for (int m = 0; m < 4; m++) begin
      total++;
      if (got.size() > m && got[m] === 18'(exp_c[m])) passed++;
      else $display("FAIL ignore_out[%0d]: got %0d required %0d", m, got.size() > m ? got[m] : 18'h3ffff, exp_c[m]);
    end
    total++;
    if (busy !== 1'b0) $display("FAIL ignore_final_idle: got busy=%b required 0", busy);
    else passed++;
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    in_a = '0;
    in_b = '0;
    sel = 0;
    repeat (2) @(negedge clk);
    test_reset();
    rst = 1'b0;
    @(negedge clk);
    test_basic();
    test_max();
    test_signed();
    test_identity_stall();
    test_random();
    test_reset_mid();
    test_ignored();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
